// File: rtl/board_ram_ctrl.sv
// Battleship board RAM controller: 10x10 grid of 2-bit cells with a request FSM, a full-board sweep clear and a free-running display read port.
// Optional ship-cell counter and all-sunk flag are built when BOARD_HITCOUNT_EN is defined.
module board_ram_ctrl (
  input  logic       clk,
  input  logic       sysreset_n,
  input  logic       req,
  input  logic [7:0] ram_addr,
  input  logic       ram_we,
  input  logic [1:0] wr_val,
  output logic [1:0] rd_val,
  output logic       rd_valid,
  output logic       busy,
  output logic       overrun,
  input  logic       clear_req,
  output logic       clear_done,
  input  logic [6:0] disp_addr,
  output logic [1:0] disp_val,
  output logic [6:0] ship_cells,
  output logic       all_sunk
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_t;

  state_t     state, state_nxt;
  logic [7:0] acc_addr;
  logic       acc_we;
  logic [1:0] acc_val;
  logic [6:0] clr_cnt;
  logic [1:0] mem [0:99];

  logic       acc_ok;
  logic [6:0] acc_idx;
  logic [1:0] old_val;
  logic       commit;
  logic       accept;
  logic       start_clr;

  function automatic logic addr_ok(input logic [7:0] a);
    return (a[7:4] <= 4'd9) && (a[3:0] <= 4'd9);
  endfunction

  function automatic logic [6:0] lin_idx(input logic [7:0] a);
    return {3'b000, a[7:4]} * 7'd10 + {3'b000, a[3:0]};
  endfunction

  assign acc_ok    = addr_ok(acc_addr);
  assign acc_idx   = lin_idx(acc_addr);
  // Out-of-bounds cells read as "hit" so software treats them as occupied.
  assign old_val   = acc_ok ? mem[acc_idx] : 2'b11;
  assign commit    = (state == ACCESS) && acc_we && acc_ok;
  assign accept    = (state == IDLE) && req && !clear_req;
  assign start_clr = (state == IDLE) && clear_req;

  assign rd_valid   = (state == RESP);
  assign busy       = (state != IDLE);
  assign clear_done = (state == CLEAR) && (clr_cnt == 7'd99);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clear_req)  state_nxt = CLEAR;
        else if (req)   state_nxt = ACCESS;
      end
      ACCESS:           state_nxt = RESP;
      RESP:             state_nxt = IDLE;
      CLEAR: begin
        if (clr_cnt == 7'd99) state_nxt = IDLE;
      end
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sysreset_n) begin
      state   <= IDLE;
      clr_cnt <= 7'd0;
      overrun <= 1'b0;
      rd_val  <= 2'b00;
    end else begin
      state <= state_nxt;
      if (req && ((state != IDLE) || clear_req)) overrun <= 1'b1;
      if (start_clr)               clr_cnt <= 7'd0;
      else if (state == CLEAR)     clr_cnt <= clr_cnt + 7'd1;
      if (state == ACCESS)         rd_val  <= old_val;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc_addr <= ram_addr;
      acc_we   <= ram_we;
      acc_val  <= wr_val;
    end
  end

  // Storage is never reset; writes are held off while reset is asserted so an aborted sweep stops cleanly.
  always_ff @(posedge clk) begin
    if (sysreset_n) begin
      if (commit)                mem[acc_idx] <= acc_val;
      else if (state == CLEAR)   mem[clr_cnt] <= 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!sysreset_n)                disp_val <= 2'b00;
    else if (disp_addr < 7'd100)    disp_val <= mem[disp_addr];
    else                            disp_val <= 2'b00;
  end

`ifdef BOARD_HITCOUNT_EN
  logic [6:0] ship_cnt;
  logic       placed;

  always_ff @(posedge clk) begin
    if (!sysreset_n) begin
      ship_cnt <= 7'd0;
      placed   <= 1'b0;
    end else if (start_clr) begin
      ship_cnt <= 7'd0;
      placed   <= 1'b0;
    end else if (commit) begin
      if ((old_val != 2'b01) && (acc_val == 2'b01))      ship_cnt <= ship_cnt + 7'd1;
      else if ((old_val == 2'b01) && (acc_val != 2'b01)) ship_cnt <= ship_cnt - 7'd1;
      if (acc_val == 2'b01) placed <= 1'b1;
    end
  end

  assign ship_cells = ship_cnt;
  assign all_sunk   = placed && (ship_cnt == 7'd0);
`else
  assign ship_cells = 7'd0;
  assign all_sunk   = 1'b0;
`endif

endmodule

// File: tb/tb_board_ram_ctrl.sv
// Directed bench for board_ram_ctrl; covers the BOARD_HITCOUNT_EN build when that macro is defined.
module tb_board_ram_ctrl;

  logic       clk = 1'b0;
  logic       sysreset_n = 1'b0;
  logic       req = 1'b0;
  logic [7:0] ram_addr = 8'h00;
  logic       ram_we = 1'b0;
  logic [1:0] wr_val = 2'b00;
  logic [1:0] rd_val;
  logic       rd_valid;
  logic       busy;
  logic       overrun;
  logic       clear_req = 1'b0;
  logic       clear_done;
  logic [6:0] disp_addr = 7'd0;
  logic [1:0] disp_val;
  logic [6:0] ship_cells;
  logic       all_sunk;

  int errors = 0;
  int checks = 0;

  board_ram_ctrl dut (
    .clk(clk), .sysreset_n(sysreset_n), .req(req), .ram_addr(ram_addr),
    .ram_we(ram_we), .wr_val(wr_val), .rd_val(rd_val), .rd_valid(rd_valid),
    .busy(busy), .overrun(overrun), .clear_req(clear_req), .clear_done(clear_done),
    .disp_addr(disp_addr), .disp_val(disp_val), .ship_cells(ship_cells), .all_sunk(all_sunk)
  );

  always #5 clk = ~clk;

  // One request; lat is the number of edges from launch to the rd_valid sample (0 = timed out).
  task automatic access(input logic [7:0] a, input logic we, input logic [1:0] v,
                        output logic [1:0] rv, output int lat);
    @(posedge clk); #1;
    req = 1'b1; ram_addr = a; ram_we = we; wr_val = v;
    lat = 0; rv = 2'bxx;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin req = 1'b0; ram_we = 1'b0; end
      if (rd_valid) begin lat = k; rv = rd_val; break; end
    end
  endtask

  task automatic disp_read(input logic [6:0] i, output logic [1:0] d);
    @(posedge clk); #1;
    disp_addr = i;
    @(posedge clk); #1;
    d = disp_val;
  endtask

  task automatic run_clear(output int busy_cyc, output int done_at, output int pulses);
    @(posedge clk); #1;
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    busy_cyc = 0; done_at = 0; pulses = 0;
    for (int k = 0; k < 200; k++) begin
      if (!busy) break;
      busy_cyc++;
      if (clear_done) begin done_at = busy_cyc; pulses++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    sysreset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (rd_valid !== 1'b0)   begin errors++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
    checks++; if (rd_val !== 2'b00)    begin errors++; $display("FAIL reset_rd_val got=%b want=00", rd_val); end
    checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_clear_done got=%b want=0", clear_done); end
    checks++; if (disp_val !== 2'b00)  begin errors++; $display("FAIL reset_disp_val got=%b want=00", disp_val); end
    checks++; if (ship_cells !== 7'd0) begin errors++; $display("FAIL reset_ship_cells got=%0d want=0", ship_cells); end
    checks++; if (all_sunk !== 1'b0)   begin errors++; $display("FAIL reset_all_sunk got=%b want=0", all_sunk); end
    sysreset_n = 1'b1;
  endtask

  task automatic test_clear;
    int bc, da, np, lat;
    logic [1:0] rv, d;
    run_clear(bc, da, np);
    checks++; if (bc !== 100) begin errors++; $display("FAIL clear_busy_cycles got=%0d want=100", bc); end
    checks++; if (da !== 100) begin errors++; $display("FAIL clear_done_cycle got=%0d want=100", da); end
    checks++; if (np !== 1)   begin errors++; $display("FAIL clear_done_pulses got=%0d want=1", np); end
    access(8'h00, 1'b0, 2'b00, rv, lat);
    checks++; if (rv !== 2'b00) begin errors++; $display("FAIL clear_read_00 got=%b want=00", rv); end
    disp_read(7'd99, d);
    checks++; if (d !== 2'b00) begin errors++; $display("FAIL clear_disp_99 got=%b want=00", d); end
  endtask

  task automatic test_read_write;
    int lat;
    logic [1:0] rv, d;
    access(8'h34, 1'b1, 2'b01, rv, lat);
    checks++; if (lat !== 2)     begin errors++; $display("FAIL rw_latency got=%0d want=2", lat); end
    checks++; if (rv !== 2'b00)  begin errors++; $display("FAIL rw_old_value got=%b want=00", rv); end
    access(8'h34, 1'b0, 2'b00, rv, lat);
    checks++; if (rv !== 2'b01)  begin errors++; $display("FAIL rw_read_34 got=%b want=01", rv); end
    disp_read(7'd34, d);
    checks++; if (d !== 2'b01)   begin errors++; $display("FAIL rw_disp_34 got=%b want=01", d); end
    access(8'h99, 1'b1, 2'b10, rv, lat);
    access(8'h99, 1'b0, 2'b00, rv, lat);
    checks++; if (rv !== 2'b10)  begin errors++; $display("FAIL rw_read_99 got=%b want=10", rv); end
    disp_read(7'd99, d);
    checks++; if (d !== 2'b10)   begin errors++; $display("FAIL rw_disp_99 got=%b want=10", d); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rw_overrun got=%b want=0", overrun); end
  endtask

  task automatic test_oob;
    int lat;
    logic [1:0] rv, d;
    access(8'hFF, 1'b0, 2'b00, rv, lat);
    checks++; if (rv !== 2'b11) begin errors++; $display("FAIL oob_read_FF got=%b want=11", rv); end
    access(8'h3A, 1'b0, 2'b00, rv, lat);
    checks++; if (rv !== 2'b11) begin errors++; $display("FAIL oob_read_3A got=%b want=11", rv); end
    access(8'hA0, 1'b1, 2'b01, rv, lat);
    checks++; if (rv !== 2'b11) begin errors++; $display("FAIL oob_write_A0_rd got=%b want=11", rv); end
    disp_read(7'd100, d);
    checks++; if (d !== 2'b00)  begin errors++; $display("FAIL oob_disp_100 got=%b want=00", d); end
    disp_read(7'd0, d);
    checks++; if (d !== 2'b00)  begin errors++; $display("FAIL oob_disp_0 got=%b want=00", d); end
    access(8'h34, 1'b0, 2'b00, rv, lat);
    checks++; if (rv !== 2'b01) begin errors++; $display("FAIL oob_read_34 got=%b want=01", rv); end
  endtask

  task automatic test_back_to_back;
    int pulses;
    int lat;
    logic [1:0] rv;
    @(posedge clk); #1;
    req = 1'b1; ram_addr = 8'h34; ram_we = 1'b0;
    @(posedge clk); #1;
    ram_we = 1'b1; wr_val = 2'b11;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin req = 1'b0; ram_we = 1'b0; end
      if (rd_valid) pulses++;
    end
    checks++; if (pulses !== 1)     begin errors++; $display("FAIL b2b_rd_valid_pulses got=%0d want=1", pulses); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got=%b want=1", overrun); end
    access(8'h34, 1'b0, 2'b00, rv, lat);
    checks++; if (rv !== 2'b01)     begin errors++; $display("FAIL b2b_dropped_write got=%b want=01", rv); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun_sticky got=%b want=1", overrun); end
  endtask

  task automatic test_hitcount;
    int bc, da, np, lat;
    logic [1:0] rv;
    run_clear(bc, da, np);
    access(8'h00, 1'b1, 2'b01, rv, lat);
    access(8'h01, 1'b1, 2'b01, rv, lat);
`ifdef BOARD_HITCOUNT_EN
    checks++; if (ship_cells !== 7'd2) begin errors++; $display("FAIL hc_two_ships got=%0d want=2", ship_cells); end
    checks++; if (all_sunk !== 1'b0)   begin errors++; $display("FAIL hc_not_sunk got=%b want=0", all_sunk); end
    access(8'h00, 1'b1, 2'b11, rv, lat);
    checks++; if (ship_cells !== 7'd1) begin errors++; $display("FAIL hc_one_hit got=%0d want=1", ship_cells); end
    access(8'h01, 1'b1, 2'b11, rv, lat);
    checks++; if (ship_cells !== 7'd0) begin errors++; $display("FAIL hc_all_hit got=%0d want=0", ship_cells); end
    checks++; if (all_sunk !== 1'b1)   begin errors++; $display("FAIL hc_all_sunk got=%b want=1", all_sunk); end
    access(8'h00, 1'b1, 2'b11, rv, lat);
    checks++; if (ship_cells !== 7'd0) begin errors++; $display("FAIL hc_rewrite_hit got=%0d want=0", ship_cells); end
`else
    checks++; if (ship_cells !== 7'd0) begin errors++; $display("FAIL hc_tied_count got=%0d want=0", ship_cells); end
    checks++; if (all_sunk !== 1'b0)   begin errors++; $display("FAIL hc_tied_sunk got=%b want=0", all_sunk); end
`endif
  endtask

  task automatic test_clear_abort;
    int lat, np;
    logic [1:0] rv, d;
    access(8'h00, 1'b1, 2'b10, rv, lat);
    access(8'h49, 1'b1, 2'b10, rv, lat);
    access(8'h50, 1'b1, 2'b10, rv, lat);
    @(posedge clk); #1;
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    np = 0;
    for (int k = 0; k < 50; k++) begin
      if (clear_done) np++;
      @(posedge clk); #1;
    end
    sysreset_n = 1'b0;
    @(posedge clk); #1;
    if (clear_done) np++;
    @(posedge clk); #1;
    sysreset_n = 1'b1;
    checks++; if (np !== 0)         begin errors++; $display("FAIL abort_clear_done got=%0d want=0", np); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL abort_overrun got=%b want=0", overrun); end
    disp_read(7'd0, d);
    checks++; if (d !== 2'b00) begin errors++; $display("FAIL abort_cell_0 got=%b want=00", d); end
    disp_read(7'd49, d);
    checks++; if (d !== 2'b00) begin errors++; $display("FAIL abort_cell_49 got=%b want=00", d); end
    disp_read(7'd50, d);
    checks++; if (d !== 2'b10) begin errors++; $display("FAIL abort_cell_50 got=%b want=10", d); end
    access(8'h49, 1'b0, 2'b00, rv, lat);
    checks++; if (rv !== 2'b00) begin errors++; $display("FAIL abort_read_49 got=%b want=00", rv); end
  endtask

  task automatic test_req_clear_collision;
    int lat, bc;
    logic [1:0] rv;
    access(8'h77, 1'b1, 2'b10, rv, lat);
    @(posedge clk); #1;
    req = 1'b1; clear_req = 1'b1; ram_addr = 8'h77; ram_we = 1'b1; wr_val = 2'b01;
    @(posedge clk); #1;
    req = 1'b0; clear_req = 1'b0; ram_we = 1'b0;
    bc = 0;
    for (int k = 0; k < 200; k++) begin
      if (!busy) break;
      bc++;
      @(posedge clk); #1;
    end
    checks++; if (bc !== 100)       begin errors++; $display("FAIL coll_clear_cycles got=%0d want=100", bc); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL coll_overrun got=%b want=1", overrun); end
    access(8'h77, 1'b0, 2'b00, rv, lat);
    checks++; if (rv !== 2'b00)     begin errors++; $display("FAIL coll_read_77 got=%b want=00", rv); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_read_write();
    test_oob();
    test_back_to_back();
    test_hitcount();
    test_clear_abort();
    test_req_clear_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_ram_ctrl.md
BOARD_RAM_CTRL -- requirements
Module: board_ram_ctrl

Interface
REQ-001 clk  in  1  system clock; all logic on rising edge.
REQ-002 sysreset_n  in  1  synchronous, active-low reset.
REQ-003 req  in  1  one-cycle access request pulse (qualified PicoBlaze write to cursor-check or RAM-write port).
REQ-004 ram_addr  in  8  cell address {row[3:0],col[3:0]}; 8'hFF = out-of-bounds marker.
REQ-005 ram_we  in  1  1 = write wr_val, 0 = read; sampled with req.
REQ-006 wr_val  in  2  cell code: 00 empty, 01 ship, 10 miss, 11 hit.
REQ-007 rd_val  out  2  cell value returned to the interface (ReturnReadRAMValue).
REQ-008 rd_valid  out  1  one-cycle pulse, rd_val valid.
REQ-009 busy  out  1  high while an access or clear is in progress.
REQ-010 overrun  out  1  sticky; a req was dropped.
REQ-011 clear_req  in  1  one-cycle pulse; wipe the whole board to 00.
REQ-012 clear_done  out  1  one-cycle pulse at end of clear.
REQ-013 disp_addr  in  7  linear display read index 0..99.
REQ-014 disp_val  out  2  display read data, 1-cycle latency; 00 for index >99.
REQ-015 ship_cells  out  7  count of cells holding 01 (option, REQ-036).
REQ-016 all_sunk  out  1  high when ship_cells==0 after at least one ship write (option).

Function
REQ-017 Storage: 100 cells x 2 bits; linear index = row*10+col.
REQ-018 Address valid iff row<=9 and col<=9; every other value, including 8'hFF, is out-of-bounds (OOB).
REQ-019 FSM states: IDLE, ACCESS, RESP, CLEAR.
REQ-020 IDLE: on req, latch ram_addr/ram_we/wr_val -> ACCESS; on clear_req -> CLEAR with sweep counter=0.
REQ-021 ACCESS: capture the old cell value into rd_val (read-before-write); if ram_we and address valid, write wr_val -> RESP.
REQ-022 OOB access: no storage change; rd_val=2'b11 so the cell reads as occupied.
REQ-023 RESP: rd_valid=1 for exactly one cycle -> IDLE.
REQ-024 Latency: req at cycle N -> rd_valid high at N+2 -> next req accepted at N+3.
REQ-025 busy=1 in ACCESS, RESP, CLEAR; 0 in IDLE.
REQ-026 req while busy: ignored, overrun set, state unaffected.
REQ-027 req and clear_req in the same IDLE cycle: clear wins, req dropped, overrun set.
REQ-028 CLEAR: write 00 to index = counter each cycle, counter 0..99; at 99, clear_done pulses the same cycle -> IDLE; duration 100 cycles.
REQ-029 clear_req while busy: ignored; overrun unaffected.
REQ-030 rd_val holds its last value until the next ACCESS.
REQ-031 Display port: independent of the FSM, never stalls; during CLEAR it returns current storage contents.
REQ-032 overrun clears only on reset.

Reset
REQ-033 sysreset_n low on a clock edge: FSM->IDLE, rd_val=00, rd_valid=0, busy=0, overrun=0, clear_done=0, disp_val=00, sweep counter=0, ship_cells=0, all_sunk=0, placed flag=0.
REQ-034 Reset does not initialise storage; software issues clear_req after reset.
REQ-035 Reset mid-ACCESS or mid-CLEAR aborts: no rd_valid or clear_done pulse; partially cleared cells stay as written.

Configuration
REQ-036 Macro BOARD_HITCOUNT_EN defined: ship_cells tracks cells holding 01.
REQ-037 With the macro, ship_cells changes only on a committed write: +1 when a non-01 cell becomes 01; -1 when a 01 cell becomes non-01; unchanged otherwise.
REQ-038 With the macro, CLEAR zeroes ship_cells and the placed flag; placed flag sets on the first write of 01; all_sunk = placed & (ship_cells==0).
REQ-039 Macro undefined: ship_cells tied 0, all_sunk tied 0, no counter logic.

Verification
REQ-040 After reset, clear_req: busy high 100 cycles, clear_done on the 100th; read of 8'h00 -> rd_val=00.
REQ-041 Write 01 to 8'h34 at cycle N: rd_valid at N+2 with rd_val=00 (old value); read 8'h34 -> rd_val=01; disp_addr=34 -> disp_val=01 next cycle.
REQ-042 Read 8'hFF and 8'h3A -> rd_val=11 each; write 01 to 8'hA0 -> storage unchanged (disp index 100 -> 00).
REQ-043 req at N and again at N+1 -> second req dropped, overrun=1, exactly one rd_valid.
REQ-044 BOARD_HITCOUNT_EN: write 01 to 8'h00 and 8'h01 -> ship_cells=2; write 11 to both -> ship_cells=0, all_sunk=1; rewrite 11 to 8'h00 -> ship_cells=0.
REQ-045 clear_req then sysreset_n low at sweep counter 50 -> FSM IDLE, no clear_done, cells 0..49 read 00.
